// File: rtl/icache_mem_arbiter.sv
// Shares one memory bus between the I-cache refill port and the D-cache port.
// Round-robin grant, one latched command outstanding, beats routed back to the owner.
module icache_mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  io_i_cmd_valid,
   output logic                  io_i_cmd_ready,
   input  logic [ADDR_W-1:0]     io_i_cmd_payload_address,
   input  logic [2:0]            io_i_cmd_payload_size,
   output logic                  io_i_rsp_valid,
   output logic [DATA_W-1:0]     io_i_rsp_payload_data,
   output logic                  io_i_rsp_payload_error,
   input  logic                  io_d_cmd_valid,
   output logic                  io_d_cmd_ready,
   input  logic                  io_d_cmd_payload_wr,
   input  logic [ADDR_W-1:0]     io_d_cmd_payload_address,
   input  logic [DATA_W-1:0]     io_d_cmd_payload_data,
   input  logic [DATA_W/8-1:0]   io_d_cmd_payload_mask,
   input  logic [2:0]            io_d_cmd_payload_size,
   output logic                  io_d_rsp_valid,
   output logic [DATA_W-1:0]     io_d_rsp_payload_data,
   output logic                  io_d_rsp_payload_error,
   output logic                  io_mem_cmd_valid,
   input  logic                  io_mem_cmd_ready,
   output logic                  io_mem_cmd_payload_wr,
   output logic [ADDR_W-1:0]     io_mem_cmd_payload_address,
   output logic [DATA_W-1:0]     io_mem_cmd_payload_data,
   output logic [DATA_W/8-1:0]   io_mem_cmd_payload_mask,
   output logic [2:0]            io_mem_cmd_payload_size,
   input  logic                  io_mem_rsp_valid,
   input  logic [DATA_W-1:0]     io_mem_rsp_payload_data,
   input  logic                  io_mem_rsp_payload_error,
   output logic                  io_busy,
   output logic                  io_owner,
   output logic                  io_stray_rsp
);

   localparam int BEAT_LG = $clog2(DATA_W / 8);
   localparam int CNT_W   = (7 - BEAT_LG) > 5 ? (7 - BEAT_LG) : 5;

   typedef enum logic [1:0] {IDLE, CMD, RSP} arbState_t;

   arbState_t        state;
   logic             prio;
   logic             owner;
   logic [CNT_W-1:0] beatCnt;
   logic [CNT_W-1:0] lastCnt;
   logic             grantI;
   logic             grantD;
   logic             rspFire;

   // Grants are gated by reset so every output reads 0 while reset is held.
   assign grantI = reset && (state == IDLE) && io_i_cmd_valid && (!io_d_cmd_valid || !prio);
   assign grantD = reset && (state == IDLE) && io_d_cmd_valid && (!io_i_cmd_valid || prio);

   assign io_i_cmd_ready = grantI;
   assign io_d_cmd_ready = grantD;

   assign rspFire                = (state == RSP) && io_mem_rsp_valid;
   assign io_i_rsp_valid         = rspFire && !owner;
   assign io_d_rsp_valid         = rspFire && owner;
   assign io_i_rsp_payload_data  = io_i_rsp_valid ? io_mem_rsp_payload_data : '0;
   assign io_i_rsp_payload_error = io_i_rsp_valid && io_mem_rsp_payload_error;
   assign io_d_rsp_payload_data  = io_d_rsp_valid ? io_mem_rsp_payload_data : '0;
   assign io_d_rsp_payload_error = io_d_rsp_valid && io_mem_rsp_payload_error;

   assign io_stray_rsp     = reset && io_mem_rsp_valid && (state != RSP);
   assign io_busy          = (state != IDLE);
   assign io_owner         = owner;
   assign io_mem_cmd_valid = (state == CMD);

   // Index of the last beat: writes are single-beat, reads cover 2^size bytes.
   always_comb begin
      // NOTE: default first so no path through this block leaves lastCnt unassigned (no latch).
      lastCnt = '0;
      if (!io_mem_cmd_payload_wr && (io_mem_cmd_payload_size > 3'(BEAT_LG)))
         lastCnt = CNT_W'((32'd1 << (io_mem_cmd_payload_size - 3'(BEAT_LG))) - 32'd1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: all state updates below are non-blocking so every register samples pre-edge values.
         state                      <= IDLE;
         prio                       <= 1'b0;
         owner                      <= 1'b0;
         beatCnt                    <= '0;
         io_mem_cmd_payload_wr      <= 1'b0;
         io_mem_cmd_payload_address <= '0;
         io_mem_cmd_payload_data    <= '0;
         io_mem_cmd_payload_mask    <= '0;
         io_mem_cmd_payload_size    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grantI || grantD) begin
                  owner                      <= grantD;
                  io_mem_cmd_payload_wr      <= grantD && io_d_cmd_payload_wr;
                  io_mem_cmd_payload_address <= grantD ? io_d_cmd_payload_address : io_i_cmd_payload_address;
                  io_mem_cmd_payload_data    <= grantD ? io_d_cmd_payload_data : '0;
                  io_mem_cmd_payload_mask    <= grantD ? io_d_cmd_payload_mask : '0;
                  io_mem_cmd_payload_size    <= grantD ? io_d_cmd_payload_size : io_i_cmd_payload_size;
                  state                      <= CMD;
               end
            end
            CMD: begin
               if (io_mem_cmd_ready) begin
                  beatCnt <= lastCnt;
                  state   <= RSP;
               end
            end
            RSP: begin
               if (io_mem_rsp_valid) begin
                  if (beatCnt == '0) begin
                     state <= IDLE;
                     prio  <= ~owner;
                  end else begin
                     beatCnt <= beatCnt - CNT_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
